lcd_result_writer: RTL and testbench

LCD_RESULT_WRITER -- requirements
Module: lcd_result_writer

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/bin2bcd.sv | 52 +++++
 rtl/lcd_result_writer.sv | 108 ++++++++++
 tb/tb_lcd_result_writer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, FSM encoding and the character-field helper for
// the LCD result writer.
`timescale 1ns/1ps
package lcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_ADDR = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_E      = 8'h45;
  localparam logic [7:0] CH_R      = 8'h52;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;   // set DDRAM address, line 2 col 0

  // Character at field position pos (0 = leftmost/sign column, 5 = units).
  // bcd holds five digits, bcd[19:16] most significant.
  function automatic logic [7:0] field_char(input logic [2:0]  pos,
                                            input logic [19:0] bcd,
                                            input logic        neg,
                                            input logic        err);
    logic [2:0] lead;  // position of first displayed digit (units always shown)
    logic [3:0] d;
    logic [7:0] ch;
    lead = 3'd5;
    if (bcd[7:4]   != 4'd0) lead = 3'd4;
    if (bcd[11:8]  != 4'd0) lead = 3'd3;
    if (bcd[15:12] != 4'd0) lead = 3'd2;
    if (bcd[19:16] != 4'd0) lead = 3'd1;
    case (pos)
      3'd1:    d = bcd[19:16];
      3'd2:    d = bcd[15:12];
      3'd3:    d = bcd[11:8];
      3'd4:    d = bcd[7:4];
      default: d = bcd[3:0];
    endcase
    if (err) begin
      if (pos == 3'd3)                    ch = CH_E;
      else if (pos == 3'd4 || pos == 3'd5) ch = CH_R;
      else                                ch = CH_SPACE;
    end else if (pos >= lead) begin
      ch = CH_ZERO + {4'd0, d};
    end else if (neg && pos == lead - 3'd1) begin
      ch = CH_MINUS;
    end else begin
      ch = CH_SPACE;
    end
    return ch;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: sequential shift-add-3 (double dabble) converter.
//   clk, rst_n : clock, async active-low reset
//   start      : load bin and begin; takes exactly 16 following cycles
//   bin        : 16-bit unsigned input
//   bcd        : 5-digit BCD result, bcd[19:16] most significant
//   done       : high in the cycle that performs the final shift, so bcd is
//                valid from the next cycle on
`timescale 1ns/1ps
module bin2bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [15:0] sh;
  logic [3:0]  cnt;
  logic        active;
  logic [15:0] adj_lo;

  // Only the low four digits need the add-3 correction: with a 16-bit input
  // the top digit is at most 3 before the last shift.
  always_comb begin
    adj_lo = bcd[15:0];
    for (int i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj_lo[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  assign done = active && (cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh     <= '0;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh     <= bin;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      bcd <= {bcd[18:16], adj_lo, sh[15]};
      sh  <= {sh[14:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (cnt == 4'd15) active <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_result_writer.sv
// lcd_result_writer: formats a signed 16-bit result (or an error marker) as a
// right-aligned 6-character field on LCD line 2 and pushes the command and
// character words into a display FIFO.
//   clk      : clock
//   RST      : async active-low reset
//   START    : request (accepted only when idle)
//   VALUE    : two's-complement result, ERR : error flag, both sampled on accept
//   BUSY     : request in progress
//   WR_EN    : FIFO write strobe
//   DATA_OUT : {RS, byte}; 9'h000 whenever WR_EN is low
// Outputs are registered from the next-state, so the word on DATA_OUT always
// belongs to the current state.
`timescale 1ns/1ps
module lcd_result_writer
  import lcd_pkg::*;
#(
  parameter int         WIDTH     = 16,
  parameter logic [7:0] LINE_ADDR = CMD_LINE2,
  parameter int         FIELD     = 6
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] VALUE,
  input  logic             ERR,
  output logic             BUSY,
  output logic             WR_EN,
  output logic [8:0]       DATA_OUT
);

  state_t      state, nxt_state;
  logic [2:0]  idx, nxt_idx;
  logic        accept;
  logic        neg_q, err_q;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic        conv_done;
  logic        nxt_wr;
  logic [8:0]  nxt_data;

  // |-32768| wraps to 16'h8000, which is exactly 32768 as unsigned.
  assign mag = VALUE[WIDTH-1] ? 16'(-VALUE) : 16'(VALUE);

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst_n (RST),
    .start (accept && !ERR),
    .bin   (mag),
    .bcd   (bcd),
    .done  (conv_done)
  );

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (START) begin
        accept    = 1'b1;
        nxt_state = ERR ? S_ADDR : S_CONV;
      end
      S_CONV: if (conv_done) nxt_state = S_ADDR;
      S_ADDR: begin
        nxt_state = S_EMIT;
        nxt_idx   = 3'd0;
      end
      S_EMIT: begin
        if (idx == 3'(FIELD-1)) begin
          nxt_state = S_IDLE;
          nxt_idx   = 3'd0;
        end else begin
          nxt_idx = idx + 3'd1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    nxt_wr   = (nxt_state == S_ADDR) || (nxt_state == S_EMIT);
    nxt_data = 9'h000;
    if (nxt_state == S_ADDR)
      nxt_data = {1'b0, LINE_ADDR};
    else if (nxt_state == S_EMIT)
      nxt_data = {1'b1, field_char(nxt_idx, bcd, neg_q, err_q)};
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      idx      <= 3'd0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      BUSY     <= 1'b0;
      WR_EN    <= 1'b0;
      DATA_OUT <= 9'h000;
    end else begin
      state    <= nxt_state;
      idx      <= nxt_idx;
      BUSY     <= (nxt_state != S_IDLE);
      WR_EN    <= nxt_wr;
      DATA_OUT <= nxt_data;
      if (accept) begin
        neg_q <= VALUE[WIDTH-1];
        err_q <= ERR;
      end
    end
  end

endmodule

// File: tb/tb_lcd_result_writer.sv
// Directed bench for lcd_result_writer: expected word streams and latencies
// are hand-computed constants.
`timescale 1ns/1ps
module tb_lcd_result_writer;

  logic        clk = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] VALUE;
  logic        ERR;
  logic        BUSY;
  logic        WR_EN;
  logic [8:0]  DATA_OUT;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  lcd_result_writer #(.WIDTH(16), .LINE_ADDR(8'hC0), .FIELD(6)) dut (
    .clk      (clk),
    .RST      (RST),
    .START    (START),
    .VALUE    (VALUE),
    .ERR      (ERR),
    .BUSY     (BUSY),
    .WR_EN    (WR_EN),
    .DATA_OUT (DATA_OUT)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request in the current cycle and collect its words. inj != 0
  // raises START again (with another value) in that cycle while busy.
  // Returns one cycle after the last word, i.e. the cycle BUSY should fall.
  task automatic run_req(input string tag, input logic [15:0] v, input logic e,
                         input logic [62:0] exp, input int exp_lat, input int inj);
    logic [8:0] got [7];
    int cyc, n, first, idle_bad;
    VALUE = v; ERR = e; START = 1'b1;
    tick();
    START = 1'b0; VALUE = 16'h1111; ERR = 1'b0;
    cyc = 1; n = 0; first = -1; idle_bad = 0;
    chk({tag, "_busy_c1"}, 32'(BUSY), 32'd1);
    while (n < 7 && cyc < 60) begin
      if (inj != 0) START = (cyc == inj);
      if (WR_EN) begin
        if (n == 0) first = cyc;
        got[n] = DATA_OUT;
        n++;
      end else if (DATA_OUT != 9'h000) begin
        idle_bad++;
      end
      tick();
      cyc++;
    end
    START = 1'b0;
    chk({tag, "_nwords"}, 32'(n), 32'd7);
    chk({tag, "_lat"}, 32'(first), 32'(exp_lat));
    chk({tag, "_idle_data"}, 32'(idle_bad), 32'd0);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp[62-9*i -: 9]));
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    chk({tag, "_wr_end"}, 32'(WR_EN), 32'd0);
  endtask

  initial begin
    int n, b;
    RST = 1'b0; START = 1'b0; VALUE = '0; ERR = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_wr",   32'(WR_EN), 32'd0);
    chk("rst_data", 32'(DATA_OUT), 32'd0);
    RST = 1'b1;
    tick();

    run_req("v1234", 16'd1234, 1'b0,
            {9'h0C0, 9'h120, 9'h120, 9'h131, 9'h132, 9'h133, 9'h134}, 17, 0);
    tick();
    run_req("vmin", 16'h8000, 1'b0,
            {9'h0C0, 9'h12D, 9'h133, 9'h132, 9'h137, 9'h136, 9'h138}, 17, 0);
    run_req("vneg5", 16'hFFFB, 1'b0,
            {9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120, 9'h12D, 9'h135}, 17, 0);
    tick(); tick();
    run_req("verr", 16'd1, 1'b1,
            {9'h0C0, 9'h120, 9'h120, 9'h120, 9'h145, 9'h152, 9'h152}, 1, 0);
    tick();

    // Second START in CONV must be dropped, not queued.
    run_req("vign", 16'd42, 1'b0,
            {9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120, 9'h134, 9'h132}, 17, 5);
    n = 0; b = 0;
    for (int i = 0; i < 25; i++) begin
      if (WR_EN) n++;
      if (BUSY) b++;
      tick();
    end
    chk("vign_no_extra_wr", 32'(n), 32'd0);
    chk("vign_no_extra_busy", 32'(b), 32'd0);

    // Back-to-back: second request issued in the cycle BUSY falls.
    run_req("vb2b_a", 16'h7FFF, 1'b0,
            {9'h0C0, 9'h120, 9'h133, 9'h132, 9'h137, 9'h136, 9'h137}, 17, 0);
    run_req("vb2b_b", 16'd0, 1'b0,
            {9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120, 9'h120, 9'h130}, 17, 0);
    tick();

    // Reset during EMIT, right after the 3rd word is on the bus.
    VALUE = 16'd1234; START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      if (WR_EN) n++;
      if (n < 3) tick();
    end
    chk("rst_mid_words_seen", 32'(n), 32'd3);
    RST = 1'b0;
    #1;
    chk("rst_mid_wr",   32'(WR_EN), 32'd0);
    chk("rst_mid_data", 32'(DATA_OUT), 32'd0);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    tick(); tick();
    RST = 1'b1;
    n = 0; b = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (WR_EN) n++;
      if (BUSY) b++;
    end
    chk("rst_after_wr", 32'(n), 32'd0);
    chk("rst_after_busy", 32'(b), 32'd0);

    run_req("vpost", 16'd0, 1'b0,
            {9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120, 9'h120, 9'h130}, 17, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
